// File: rtl/stack_frame_unit_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Shared types for the stack frame unit:
//   sel_e   : push/pop source/target selector encodings
//   state_e : stack access FSM states
// -----------------------------------------------------------------------------
package stack_pkg;

  typedef enum logic [1:0] {
    SEL_REG   = 2'b00,
    SEL_PC_HI = 2'b01,
    SEL_PC_LO = 2'b10,
    SEL_CCR   = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WR   = 2'b01,
    RD   = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam int         FRAME_DEPTH_W   = 4;
  localparam logic [3:0] FRAME_DEPTH_MAX = 4'd15;

endpackage

// File: rtl/stack_frame_unit_pc_assembler.sv
// -----------------------------------------------------------------------------
// pc_assembler
// Rebuilds a return PC from two popped halves that may arrive in either order.
// A half is written whenever its enable is high. When the second, different
// half lands, o_pc_valid pulses for one cycle and both half flags clear.
// Re-writing a half that is already held just overwrites it without a pulse.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_hi_en     : write i_data into the high half
//   i_lo_en     : write i_data into the low half
//   i_data      : half-word value
//   o_pc        : {high half, low half}
//   o_pc_valid  : one-cycle pulse when both halves have been captured
// -----------------------------------------------------------------------------
module pc_assembler #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_hi_en,
  input  logic                  i_lo_en,
  input  logic [DATA_W-1:0]     i_data,
  output logic [2*DATA_W-1:0]   o_pc,
  output logic                  o_pc_valid
);

  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic              r_hi_v;
  logic              r_lo_v;
  logic              r_pc_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_hi_v     <= 1'b0;
      r_lo_v     <= 1'b0;
      r_pc_valid <= 1'b0;
    end else begin
      r_pc_valid <= 1'b0;
      if (i_hi_en) begin
        r_hi <= i_data;
        if (r_lo_v) begin
          r_pc_valid <= 1'b1;
          r_hi_v     <= 1'b0;
          r_lo_v     <= 1'b0;
        end else begin
          r_hi_v <= 1'b1;
        end
      end else if (i_lo_en) begin
        r_lo <= i_data;
        if (r_hi_v) begin
          r_pc_valid <= 1'b1;
          r_hi_v     <= 1'b0;
          r_lo_v     <= 1'b0;
        end else begin
          r_lo_v <= 1'b1;
        end
      end
    end
  end

  assign o_pc       = {r_hi, r_lo};
  assign o_pc_valid = r_pc_valid;

endmodule

// File: rtl/stack_frame_unit.sv
// -----------------------------------------------------------------------------
// stack_frame_unit
// Memory-side responder for the control unit's stack protocol. Owns the stack
// pointer (grows downward, sp points at the next free word), performs single
// word stack writes/reads on the data-memory port, reassembles popped return
// PCs and returns restored CCR values.
//
// Handshake: a request (push_valid or pop_valid) is taken on a rising edge
// where busy==0; busy then stays high until the cycle after the DONE state.
// The memory port holds mem_we/mem_addr/mem_wdata stable while mem_req is high
// and the access finishes on the edge where mem_ack is sampled high.
//
// Optional feature macro: STACK_FRAME_CHK_EN enables the interrupt frame depth
// counter (frame_depth / frame_err). Without it both outputs are tied to 0.
//
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   push_valid/push_sel/push_data    : push request, source select, reg data
//   pc_in, ccr_in                    : PC and CCR values to save
//   pop_valid/pop_sel                : pop request and target select
//   busy                             : request in progress
//   mem_req/mem_we/mem_addr/mem_wdata: data-memory access
//   mem_rdata/mem_ack                : data-memory response
//   pop_data/pop_data_valid          : popped register data
//   pc_out/pc_valid                  : reassembled return PC
//   ccr_out/ccr_valid                : restored CCR
//   sp                               : current stack pointer
//   ovf_err/unf_err/proto_err        : sticky error flags
//   frame_depth/frame_err            : interrupt frame tracking
//   dbg_state                        : current FSM state
// -----------------------------------------------------------------------------
module stack_frame_unit
  import stack_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 11,
  parameter logic [ADDR_W-1:0] SP_INIT     = 11'h7FF,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = 11'h600,
  parameter int                CCR_W       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  input  logic [1:0]        push_sel,
  input  logic [DATA_W-1:0] push_data,
  input  logic [31:0]       pc_in,
  input  logic [CCR_W-1:0]  ccr_in,
  input  logic              pop_valid,
  input  logic [1:0]        pop_sel,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_data_valid,
  output logic [31:0]       pc_out,
  output logic              pc_valid,
  output logic [CCR_W-1:0]  ccr_out,
  output logic              ccr_valid,
  output logic [ADDR_W-1:0] sp,
  output logic              ovf_err,
  output logic              unf_err,
  output logic              proto_err,
  output logic [3:0]        frame_depth,
  output logic              frame_err,
  output logic [1:0]        dbg_state
);

  state_e            r_state;
  sel_e              r_sel;
  logic [ADDR_W-1:0] r_sp;
  logic              r_busy;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_pop_data;
  logic              r_pop_data_valid;
  logic [CCR_W-1:0]  r_ccr_out;
  logic              r_ccr_valid;
  logic              r_ovf_err;
  logic              r_unf_err;
  logic              r_proto_err;

  logic [DATA_W-1:0] w_push_wdata;
  logic              w_rd_done;
  logic              w_unf_pop;
  logic              w_cap_en;
  sel_e              w_cap_sel;
  logic [DATA_W-1:0] w_cap_data;

  // Write data is chosen from the live inputs at accept and then held in
  // r_mem_wdata, so later changes of pc_in/ccr_in do not disturb the write.
  always_comb begin
    w_push_wdata = push_data;
    case (sel_e'(push_sel))
      SEL_REG:   w_push_wdata = push_data;
      SEL_PC_HI: w_push_wdata = pc_in[31:16];
      SEL_PC_LO: w_push_wdata = pc_in[15:0];
      SEL_CCR:   w_push_wdata = {{(DATA_W-CCR_W){1'b0}}, ccr_in};
      default:   w_push_wdata = push_data;
    endcase
  end

  // A PC half is captured either at the read acknowledge, or at accept time
  // (value 0) when the pop underflows and skips memory entirely.
  assign w_rd_done  = (r_state == RD) && mem_ack;
  assign w_unf_pop  = (r_state == IDLE) && pop_valid && !push_valid && (r_sp == SP_INIT);
  assign w_cap_en   = w_rd_done || w_unf_pop;
  assign w_cap_sel  = w_rd_done ? r_sel : sel_e'(pop_sel);
  assign w_cap_data = w_rd_done ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_sel            <= SEL_REG;
      r_sp             <= SP_INIT;
      r_busy           <= 1'b0;
      r_mem_req        <= 1'b0;
      r_mem_we         <= 1'b0;
      r_mem_addr       <= '0;
      r_mem_wdata      <= '0;
      r_pop_data       <= '0;
      r_pop_data_valid <= 1'b0;
      r_ccr_out        <= '0;
      r_ccr_valid      <= 1'b0;
      r_ovf_err        <= 1'b0;
      r_unf_err        <= 1'b0;
      r_proto_err      <= 1'b0;
    end else begin
      r_pop_data_valid <= 1'b0;
      r_ccr_valid      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (push_valid) begin
            // Push has priority; a coincident pop is dropped and flagged.
            r_sel  <= sel_e'(push_sel);
            r_busy <= 1'b1;
            if (pop_valid) r_proto_err <= 1'b1;
            if (r_sp == STACK_LIMIT) begin
              r_ovf_err <= 1'b1;
              r_state   <= DONE;
            end else begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_sp;
              r_mem_wdata <= w_push_wdata;
              r_state     <= WR;
            end
          end else if (pop_valid) begin
            r_sel  <= sel_e'(pop_sel);
            r_busy <= 1'b1;
            if (r_sp == SP_INIT) begin
              // Empty stack: report the pop with zero data, no memory access.
              r_unf_err <= 1'b1;
              r_state   <= DONE;
              case (sel_e'(pop_sel))
                SEL_REG: begin
                  r_pop_data       <= '0;
                  r_pop_data_valid <= 1'b1;
                end
                SEL_CCR: begin
                  r_ccr_out   <= '0;
                  r_ccr_valid <= 1'b1;
                end
                default: ;
              endcase
            end else begin
              r_mem_req  <= 1'b1;
              r_mem_we   <= 1'b0;
              r_mem_addr <= r_sp + 1'b1;
              r_state    <= RD;
            end
          end
        end
        WR: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_sp      <= r_sp - 1'b1;
            r_state   <= DONE;
          end
        end
        RD: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_sp      <= r_sp + 1'b1;
            r_state   <= DONE;
            case (r_sel)
              SEL_REG: begin
                r_pop_data       <= mem_rdata;
                r_pop_data_valid <= 1'b1;
              end
              SEL_CCR: begin
                r_ccr_out   <= mem_rdata[CCR_W-1:0];
                r_ccr_valid <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy    <= 1'b0;
          r_mem_req <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  pc_assembler #(
    .DATA_W(DATA_W)
  ) u_pc_assembler (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_hi_en    (w_cap_en && (w_cap_sel == SEL_PC_HI)),
    .i_lo_en    (w_cap_en && (w_cap_sel == SEL_PC_LO)),
    .i_data     (w_cap_data),
    .o_pc       (pc_out),
    .o_pc_valid (pc_valid)
  );

`ifdef STACK_FRAME_CHK_EN
  logic [FRAME_DEPTH_W-1:0] r_frame_depth;
  logic                     r_frame_err;
  logic                     w_ccr_push_done;
  logic                     w_ccr_pop_acc;

  // Frames open when a CCR write completes and close when a CCR pop is
  // accepted (also when that pop underflows).
  assign w_ccr_push_done = (r_state == WR) && mem_ack && (r_sel == SEL_CCR);
  assign w_ccr_pop_acc   = (r_state == IDLE) && pop_valid && !push_valid &&
                           (sel_e'(pop_sel) == SEL_CCR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_depth <= '0;
      r_frame_err   <= 1'b0;
    end else if (w_ccr_push_done) begin
      if (r_frame_depth != FRAME_DEPTH_MAX) r_frame_depth <= r_frame_depth + 1'b1;
    end else if (w_ccr_pop_acc) begin
      if (r_frame_depth == '0) r_frame_err   <= 1'b1;
      else                     r_frame_depth <= r_frame_depth - 1'b1;
    end
  end

  assign frame_depth = r_frame_depth;
  assign frame_err   = r_frame_err;
`else
  assign frame_depth = '0;
  assign frame_err   = 1'b0;
`endif

  assign busy           = r_busy;
  assign mem_req        = r_mem_req;
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_wdata      = r_mem_wdata;
  assign pop_data       = r_pop_data;
  assign pop_data_valid = r_pop_data_valid;
  assign ccr_out        = r_ccr_out;
  assign ccr_valid      = r_ccr_valid;
  assign sp             = r_sp;
  assign ovf_err        = r_ovf_err;
  assign unf_err        = r_unf_err;
  assign proto_err      = r_proto_err;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_stack_frame_unit.sv
// -----------------------------------------------------------------------------
// tb_stack_frame_unit
// Directed and randomized stimulus for stack_frame_unit. The bench plays the
// data memory and keeps a reference stack as a queue of words; the expected
// stack pointer is SP_INIT minus the queue depth.
// -----------------------------------------------------------------------------
module tb_stack_frame_unit;

  localparam logic [10:0] SP_INIT = 11'h7FF;
  localparam logic [10:0] LIMIT   = 11'h600;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        push_valid = 0, pop_valid = 0, mem_ack = 0;
  logic [1:0]  push_sel = 0, pop_sel = 0;
  logic [15:0] push_data = 0, mem_rdata = 0;
  logic [31:0] pc_in = 0;
  logic [2:0]  ccr_in = 0;
  logic        busy, mem_req, mem_we, pop_data_valid, pc_valid, ccr_valid;
  logic        ovf_err, unf_err, proto_err, frame_err;
  logic [10:0] mem_addr, sp;
  logic [15:0] mem_wdata, pop_data;
  logic [31:0] pc_out;
  logic [2:0]  ccr_out;
  logic [3:0]  frame_depth;
  logic [1:0]  dbg_state;

  stack_frame_unit dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_sel(push_sel), .push_data(push_data),
    .pc_in(pc_in), .ccr_in(ccr_in),
    .pop_valid(pop_valid), .pop_sel(pop_sel),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pop_data(pop_data), .pop_data_valid(pop_data_valid),
    .pc_out(pc_out), .pc_valid(pc_valid),
    .ccr_out(ccr_out), .ccr_valid(ccr_valid),
    .sp(sp), .ovf_err(ovf_err), .unf_err(unf_err), .proto_err(proto_err),
    .frame_depth(frame_depth), .frame_err(frame_err), .dbg_state(dbg_state)
  );

  // scoreboard state
  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] bmem [0:2047];
  bit m_ovf = 0, m_unf = 0, m_proto = 0;
  bit m_hi_set = 0, m_lo_set = 0;
  logic [15:0] m_hi = 0, m_lo = 0;

  // per-operation observations
  bit          req_seen, addr_stable, op_done;
  logic        s_we;
  logic [10:0] s_addr;
  logic [15:0] s_wdata;
  int          busy_cnt, pd_cnt, pc_cnt, ccr_cnt;
  logic [15:0] pd_val;
  logic [31:0] pc_val;
  logic [2:0]  ccr_val;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] push_word(input logic [1:0] sel, input logic [15:0] data);
    case (sel)
      2'b00:   return data;
      2'b01:   return pc_in[31:16];
      2'b10:   return pc_in[15:0];
      default: return {13'b0, ccr_in};
    endcase
  endfunction

  // Issue one request, then act as the memory until the unit is idle again.
  task automatic run_op(input bit is_push, input bit both, input logic [1:0] sel,
                        input logic [15:0] data, input int ack_dly);
    int wait_cnt;
    req_seen = 0; addr_stable = 1; op_done = 0;
    busy_cnt = 0; pd_cnt = 0; pc_cnt = 0; ccr_cnt = 0; wait_cnt = 0;
    s_we = 0; s_addr = 0; s_wdata = 0;
    @(negedge clk);
    if (is_push) begin
      push_valid = 1; push_sel = sel; push_data = data; pop_valid = both; pop_sel = sel;
    end else begin
      pop_valid = 1; pop_sel = sel;
    end
    @(negedge clk);
    push_valid = 0; pop_valid = 0;
    for (int cyc = 0; cyc < 64 && !op_done; cyc++) begin
      mem_ack = 0;
      if (!busy) op_done = 1;
      else begin
        busy_cnt++;
        if (pop_data_valid) begin pd_cnt++; pd_val = pop_data; end
        if (pc_valid)       begin pc_cnt++; pc_val = pc_out; end
        if (ccr_valid)      begin ccr_cnt++; ccr_val = ccr_out; end
        if (mem_req) begin
          if (!req_seen) begin
            req_seen = 1; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
          end else if (mem_we !== s_we || mem_addr !== s_addr || mem_wdata !== s_wdata) begin
            addr_stable = 0;
          end
          wait_cnt++;
          if (wait_cnt == ack_dly) begin
            mem_ack = 1;
            if (mem_we) bmem[mem_addr] = mem_wdata;
            else        mem_rdata = bmem[mem_addr];
          end
        end
        @(negedge clk);
      end
    end
    mem_ack = 0;
    check("op_completes", op_done, 1);
  endtask

  task automatic do_push(input logic [1:0] sel, input logic [15:0] data, input int dly, input bit both);
    logic [15:0] w;
    logic [10:0] sp_before;
    w = push_word(sel, data);
    sp_before = SP_INIT - 11'(exp_q.size());
    run_op(1, both, sel, data, dly);
    if (sp_before == LIMIT) begin
      m_ovf = 1;
      check("push_ovf_noreq", req_seen, 0);
      check("push_ovf_busy", busy_cnt, 1);
    end else begin
      check("push_req", req_seen, 1);
      check("push_we", s_we, 1);
      check("push_addr", s_addr, sp_before);
      check("push_wdata", s_wdata, w);
      check("push_stable", addr_stable, 1);
      check("push_busy", busy_cnt, dly + 1);
      exp_q.push_back(w);
    end
    if (both) m_proto = 1;
    check("push_sp", sp, SP_INIT - 11'(exp_q.size()));
    check("push_ovf_flag", ovf_err, m_ovf);
    check("push_proto_flag", proto_err, m_proto);
  endtask

  task automatic do_pop(input logic [1:0] sel, input int dly);
    logic [15:0] w;
    logic [10:0] sp_before;
    bit empty;
    sp_before = SP_INIT - 11'(exp_q.size());
    empty = (exp_q.size() == 0);
    run_op(0, 0, sel, 16'h0, dly);
    if (empty) begin
      w = 0; m_unf = 1;
      check("pop_unf_noreq", req_seen, 0);
      check("pop_unf_busy", busy_cnt, 1);
    end else begin
      w = exp_q.pop_back();
      check("pop_req", req_seen, 1);
      check("pop_we", s_we, 0);
      check("pop_addr", s_addr, sp_before + 11'd1);
      check("pop_stable", addr_stable, 1);
      check("pop_busy", busy_cnt, dly + 1);
    end
    case (sel)
      2'b00: begin
        check("pop_reg_pulse", pd_cnt, 1);
        check("pop_reg_data", pd_val, w);
      end
      2'b11: begin
        check("pop_ccr_pulse", ccr_cnt, 1);
        check("pop_ccr_data", ccr_val, w[2:0]);
      end
      default: begin
        if (sel == 2'b01) begin m_hi = w; m_hi_set = 1; end
        else              begin m_lo = w; m_lo_set = 1; end
        if (m_hi_set && m_lo_set) begin
          check("pop_pc_pulse", pc_cnt, 1);
          check("pop_pc_value", pc_val, {m_hi, m_lo});
          m_hi_set = 0; m_lo_set = 0;
        end else begin
          check("pop_pc_nopulse", pc_cnt, 0);
        end
      end
    endcase
    check("pop_sp", sp, SP_INIT - 11'(exp_q.size()));
    check("pop_unf_flag", unf_err, m_unf);
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) bmem[i] = 16'h0;

    // reset state
    #12;
    check("rst_sp", sp, SP_INIT);
    check("rst_busy", busy, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_errs", {ovf_err, unf_err, proto_err, frame_err}, 4'b0);
    check("rst_valids", {pop_data_valid, pc_valid, ccr_valid}, 3'b0);
    check("rst_frame_depth", frame_depth, 0);
    @(negedge clk);
    rst_n = 1;

    // PC save and restore, halves popped in reverse order
    pc_in = 32'h0001_0A2C;
    do_push(2'b01, 16'h0, 1, 0);
    do_push(2'b10, 16'h0, 1, 0);
    check("pc_mem_7ff", bmem[11'h7FF], 16'h0001);
    check("pc_mem_7fe", bmem[11'h7FE], 16'h0A2C);
    check("pc_sp_7fd", sp, 11'h7FD);
    do_pop(2'b10, 1);
    do_pop(2'b01, 1);
    check("pc_restored", pc_out, 32'h0001_0A2C);

    // CCR with slow memory acknowledge
    ccr_in = 3'b101;
    do_push(2'b11, 16'h0, 4, 0);
    check("ccr_busy_5", busy_cnt, 5);
    ccr_in = 3'b000;
    do_pop(2'b11, 1);
    check("ccr_restored", ccr_out, 3'b101);

    // underflow from the empty stack
    do_pop(2'b00, 1);
    check("unf_sp", sp, SP_INIT);

    // randomized mix
    for (int n = 0; n < 60; n++) begin
      if (exp_q.size() == 0 || $urandom_range(0, 1) == 1) begin
        pc_in  = $urandom;
        ccr_in = 3'($urandom_range(0, 7));
        do_push(2'($urandom_range(0, 3)), 16'($urandom), $urandom_range(1, 3), 0);
      end else begin
        do_pop(2'($urandom_range(0, 3)), $urandom_range(1, 3));
      end
    end

    // simultaneous push and pop: push serviced
    do_push(2'b00, 16'hBEEF, 1, 1);
    check("proto_flag", proto_err, 1);

    // fill to the limit, then one more push overflows
    check("pre_ovf_flag", ovf_err, 0);
    while (SP_INIT - 11'(exp_q.size()) != LIMIT) do_push(2'b00, 16'($urandom), 1, 0);
    check("fill_sp_600", sp, LIMIT);
    do_push(2'b00, 16'h5A5A, 1, 0);
    check("ovf_flag", ovf_err, 1);
    check("ovf_sp", sp, LIMIT);
    do_pop(2'b00, 2);

    // asynchronous reset in the middle of a write
    @(negedge clk);
    push_valid = 1; push_sel = 2'b00; push_data = 16'h1234;
    @(negedge clk);
    push_valid = 0;
    check("rstwr_req_before", mem_req, 1);
    #2 rst_n = 0;
    #1;
    check("rstwr_req_drop", mem_req, 0);
    check("rstwr_sp", sp, SP_INIT);
    check("rstwr_busy", busy, 0);
    check("rstwr_flags", {ovf_err, unf_err, proto_err}, 3'b0);
    @(negedge clk);
    rst_n = 1;
    exp_q.delete();
    m_ovf = 0; m_unf = 0; m_proto = 0; m_hi_set = 0; m_lo_set = 0;

    // interrupt frame tracking
    ccr_in = 3'b010;
    do_push(2'b11, 16'h0, 1, 0);
    ccr_in = 3'b001;
    do_push(2'b11, 16'h0, 2, 0);
`ifdef STACK_FRAME_CHK_EN
    check("frame_depth_2", frame_depth, 2);
`else
    check("frame_depth_off", frame_depth, 0);
`endif
    do_pop(2'b11, 1);
    do_pop(2'b11, 1);
    do_pop(2'b11, 1);
`ifdef STACK_FRAME_CHK_EN
    check("frame_depth_0", frame_depth, 0);
    check("frame_err_set", frame_err, 1);
`else
    check("frame_depth_off2", frame_depth, 0);
    check("frame_err_off", frame_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
